mac_frame_checker: RTL and testbench

Receive-side counterpart of the MAC frame generator: consumes a byte stream (preamble, SFD, header, payload, FCS, in the generator's byte order), locks onto the preamble/SFD, and extracts the destination, source and length fields. It streams out the real payload bytes, recomputes the generator's CRC32 byte by byte, and flags CRC and length errors. It sits between the PCS/MII receive path and the verification scoreboard.

---
 rtl/mac_frame_checker.sv | 233 +++++++++++++++++++++++
 tb/tb_mac_frame_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_frame_checker.sv
// Receive-side MAC frame checker: locks on preamble/SFD, extracts header
// fields, forwards real payload bytes and checks FCS and length.
module mac_frame_checker #(
  parameter int unsigned PAYLOAD_MAX_SIZE = 1500,
  parameter int unsigned MIN_PAYLOAD_SIZE = 46
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_no_padding,
  output logic [47:0] o_dest_address,
  output logic [47:0] o_src_address,
  output logic [15:0] o_payload_length,
  output logic        o_hdr_valid,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_frame_done,
  output logic        o_crc_ok,
  output logic        o_crc_err,
  output logic        o_len_err,
  output logic        o_busy
);

  localparam logic [2:0]  S_IDLE = 3'd0;
  localparam logic [2:0]  S_PRE  = 3'd1;
  localparam logic [2:0]  S_HDR  = 3'd2;
  localparam logic [2:0]  S_PAY  = 3'd3;
  localparam logic [2:0]  S_FCS  = 3'd4;
  localparam logic [15:0] MAX_LEN  = 16'(PAYLOAD_MAX_SIZE);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD_SIZE);
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  logic [2:0]  state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [15:0] pay_total_q, pay_total_d;
  logic [1:0]  fcs_cnt_q, fcs_cnt_d;
  logic [23:0] rx_fcs_q, rx_fcs_d;
  logic [31:0] crc_q, crc_d;
  logic [47:0] dest_w_q, dest_w_d;
  logic [47:0] src_w_q, src_w_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [47:0] dest_out_q, dest_out_d;
  logic [47:0] src_out_q, src_out_d;
  logic [15:0] len_out_q, len_out_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        crc_ok_q, crc_ok_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;
  logic        busy_q, busy_d;

  logic [31:0] crc_next;
  logic [15:0] len_full;
  logic [15:0] pay_size;
  logic        fcs_match;

  // One byte of the generator's CRC: byte XORed into the top, 32 shift steps, inverted.
  function automatic logic [31:0] crc_step(input logic [31:0] s, input logic [7:0] b);
    logic [31:0] x;
    x = s ^ {b, 24'h000000};
    for (int i = 0; i < 32; i++) begin
      x = x[31] ? ((x << 1) ^ CRC_POLY) : (x << 1);
    end
    return ~x;
  endfunction

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    hdr_cnt_d    = hdr_cnt_q;
    pay_cnt_d    = pay_cnt_q;
    pay_total_d  = pay_total_q;
    fcs_cnt_d    = fcs_cnt_q;
    rx_fcs_d     = rx_fcs_q;
    crc_d        = crc_q;
    dest_w_d     = dest_w_q;
    src_w_d      = src_w_q;
    len_lo_d     = len_lo_q;
    dest_out_d   = dest_out_q;
    src_out_d    = src_out_q;
    len_out_d    = len_out_q;
    hdr_valid_d  = 1'b0;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;
    crc_ok_d     = 1'b0;
    crc_err_d    = 1'b0;
    len_err_d    = 1'b0;
    crc_next     = crc_step(crc_q, i_data);
    len_full     = {i_data, len_lo_q};
    pay_size     = (len_full < MIN_LEN && !i_no_padding) ? MIN_LEN : len_full;
    fcs_match    = ({i_data, rx_fcs_q} == crc_q);

    if (i_valid) begin
      case (state_q)
        S_IDLE: begin
          if (i_data == 8'h55) begin
            state_d   = S_PRE;
            pre_cnt_d = 3'd1;
          end
        end
        S_PRE: begin
          if (i_data == 8'h55) begin
            if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
          end else if (i_data == 8'hD5 && pre_cnt_q == 3'd7) begin
            state_d   = S_HDR;
            hdr_cnt_d = 4'd0;
            crc_d     = CRC_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HDR: begin
          crc_d     = crc_next;
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          // Shift registers land the first byte of each field in its low byte.
          if (hdr_cnt_q < 4'd6) begin
            dest_w_d = {i_data, dest_w_q[47:8]};
          end else if (hdr_cnt_q < 4'd12) begin
            src_w_d = {i_data, src_w_q[47:8]};
          end else if (hdr_cnt_q == 4'd12) begin
            len_lo_d = i_data;
          end else begin
            dest_out_d  = dest_w_q;
            src_out_d   = src_w_q;
            len_out_d   = len_full;
            hdr_valid_d = 1'b1;
            if (len_full > MAX_LEN) begin
              len_err_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              pay_total_d = pay_size;
              pay_cnt_d   = 16'd0;
              fcs_cnt_d   = 2'd0;
              state_d     = (pay_size != 16'd0) ? S_PAY : S_FCS;
            end
          end
        end
        S_PAY: begin
          crc_d = crc_next;
          if (pay_cnt_q < len_out_q) begin
            data_d       = i_data;
            data_valid_d = 1'b1;
          end
          if (pay_cnt_q == pay_total_q - 16'd1) state_d = S_FCS;
          else pay_cnt_d = pay_cnt_q + 16'd1;
        end
        S_FCS: begin
          rx_fcs_d  = {i_data, rx_fcs_q[23:8]};
          fcs_cnt_d = fcs_cnt_q + 2'd1;
          if (fcs_cnt_q == 2'd3) begin
            frame_done_d = 1'b1;
            crc_ok_d     = fcs_match;
            crc_err_d    = !fcs_match;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= 3'd0;
      hdr_cnt_q    <= 4'd0;
      pay_cnt_q    <= 16'd0;
      pay_total_q  <= 16'd0;
      fcs_cnt_q    <= 2'd0;
      rx_fcs_q     <= 24'd0;
      crc_q        <= 32'd0;
      dest_w_q     <= 48'd0;
      src_w_q      <= 48'd0;
      len_lo_q     <= 8'd0;
      dest_out_q   <= 48'd0;
      src_out_q    <= 48'd0;
      len_out_q    <= 16'd0;
      hdr_valid_q  <= 1'b0;
      data_q       <= 8'd0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      crc_ok_q     <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      hdr_cnt_q    <= hdr_cnt_d;
      pay_cnt_q    <= pay_cnt_d;
      pay_total_q  <= pay_total_d;
      fcs_cnt_q    <= fcs_cnt_d;
      rx_fcs_q     <= rx_fcs_d;
      crc_q        <= crc_d;
      dest_w_q     <= dest_w_d;
      src_w_q      <= src_w_d;
      len_lo_q     <= len_lo_d;
      dest_out_q   <= dest_out_d;
      src_out_q    <= src_out_d;
      len_out_q    <= len_out_d;
      hdr_valid_q  <= hdr_valid_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      crc_ok_q     <= crc_ok_d;
      crc_err_q    <= crc_err_d;
      len_err_q    <= len_err_d;
      busy_q       <= busy_d;
    end
  end

  assign o_dest_address   = dest_out_q;
  assign o_src_address    = src_out_q;
  assign o_payload_length = len_out_q;
  assign o_hdr_valid      = hdr_valid_q;
  assign o_data           = data_q;
  assign o_data_valid     = data_valid_q;
  assign o_frame_done     = frame_done_q;
  assign o_crc_ok         = crc_ok_q;
  assign o_crc_err        = crc_err_q;
  assign o_len_err        = len_err_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_mac_frame_checker.sv
// Bench for mac_frame_checker: table of frames plus hand-written corner cases,
// with expected header/data/end-of-frame events checked through queues.
module tb_mac_frame_checker;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_no_padding;
  logic [7:0]  i_data;
  logic [47:0] o_dest_address, o_src_address;
  logic [15:0] o_payload_length;
  logic [7:0]  o_data;
  logic        o_hdr_valid, o_data_valid, o_frame_done, o_crc_ok, o_crc_err, o_len_err, o_busy;

  always #5 clk = ~clk;

  mac_frame_checker dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data), .i_no_padding(i_no_padding),
    .o_dest_address(o_dest_address), .o_src_address(o_src_address),
    .o_payload_length(o_payload_length), .o_hdr_valid(o_hdr_valid),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_frame_done(o_frame_done),
    .o_crc_ok(o_crc_ok), .o_crc_err(o_crc_err), .o_len_err(o_len_err), .o_busy(o_busy)
  );

  typedef struct {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] len;
    logic        no_pad;
    logic        gap;
    logic        corrupt;
    logic [7:0]  pay_base;
    logic [7:0]  pay_step;
    logic        exp_ok;
    logic        exp_len_err;
  } frame_t;

  typedef struct {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] len;
  } hdr_t;

  int          checks = 0;
  int          errors = 0;
  hdr_t        exp_hdr_q[$];
  logic [7:0]  exp_data_q[$];
  logic        exp_done_q[$];
  logic        exp_lenerr_q[$];
  logic [7:0]  fb[$];
  frame_t      tbl[9];
  frame_t      fr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_f(input logic [31:0] s, input logic [7:0] b);
    logic [31:0] x;
    x = s ^ {b, 24'h000000};
    for (int i = 0; i < 32; i++) x = x[31] ? ((x << 1) ^ 32'h04C11DB7) : (x << 1);
    return ~x;
  endfunction

  function automatic logic [7:0] pay_byte(input frame_t f, input int i);
    return 8'(int'(f.pay_base) + i * int'(f.pay_step));
  endfunction

  // Builds the wire bytes of a frame into fb, FCS from the bench CRC model.
  task automatic build(input frame_t f);
    logic [31:0] crc;
    logic [7:0]  b;
    int          p;
    fb.delete();
    for (int i = 0; i < 7; i++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    crc = 32'hFFFFFFFF;
    for (int k = 0; k < 14; k++) begin
      if (k < 6)       b = f.dest[8*k +: 8];
      else if (k < 12) b = f.src[8*(k-6) +: 8];
      else if (k == 12) b = f.len[7:0];
      else             b = f.len[15:8];
      fb.push_back(b);
      crc = crc_f(crc, b);
    end
    if (f.len > 16'd1500) return;
    p = (f.len < 16'd46 && !f.no_pad) ? 46 : int'(f.len);
    for (int i = 0; i < p; i++) begin
      b = (i < int'(f.len)) ? pay_byte(f, i) : 8'h00;
      fb.push_back(b);
      crc = crc_f(crc, b);
    end
    if (f.corrupt) crc[7:0] = crc[7:0] ^ 8'h01;
    for (int i = 0; i < 4; i++) fb.push_back(crc[8*i +: 8]);
  endtask

  task automatic expect_frame(input frame_t f);
    hdr_t h;
    h.dest = f.dest; h.src = f.src; h.len = f.len;
    exp_hdr_q.push_back(h);
    if (f.exp_len_err) begin
      exp_lenerr_q.push_back(1'b1);
    end else begin
      for (int i = 0; i < int'(f.len); i++) exp_data_q.push_back(pay_byte(f, i));
      exp_done_q.push_back(f.exp_ok);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_data  = b;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic send_fb(input logic gap);
    foreach (fb[i]) begin
      send_byte(fb[i]);
      if (gap) idle_cycle();
    end
  endtask

  task automatic run_frame(input frame_t f);
    i_no_padding = f.no_pad;
    build(f);
    expect_frame(f);
    send_fb(f.gap);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {o_dest_address, o_src_address, o_payload_length, o_hdr_valid, o_data,
                 o_data_valid, o_frame_done, o_crc_ok, o_crc_err, o_len_err, o_busy}, '0);
  endtask

  // Pops the matching expectation whenever the DUT emits an event.
  task automatic monitor_step();
    hdr_t h;
    logic e;
    if (o_hdr_valid) begin
      if (exp_hdr_q.size() == 0) check("hdr_unexpected", 1, 0);
      else begin
        h = exp_hdr_q.pop_front();
        check("hdr_fields", {o_dest_address, o_src_address, o_payload_length}, {h.dest, h.src, h.len});
      end
    end
    if (o_data_valid) begin
      if (exp_data_q.size() == 0) check("data_unexpected", {120'd0, o_data}, 128'h1FF);
      else check("data_byte", {120'd0, o_data}, {120'd0, exp_data_q.pop_front()});
    end
    if (o_frame_done) begin
      if (exp_done_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        e = exp_done_q.pop_front();
        check("crc_flags", {126'd0, o_crc_ok, o_crc_err}, {126'd0, e, !e});
      end
    end else if (o_crc_ok || o_crc_err) begin
      check("crc_flags_idle", {126'd0, o_crc_ok, o_crc_err}, 0);
    end
    if (o_len_err) begin
      if (exp_lenerr_q.size() == 0) check("len_err_unexpected", 1, 0);
      else check("len_err", 1, {127'd0, exp_lenerr_q.pop_front()});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 16'd8,    1'b0, 1'b0, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 16'd8,    1'b0, 1'b0, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{48'hFFFFFFFFFFFF, 48'h020000000001, 16'd3,    1'b1, 1'b1, 1'b0, 8'hA1, 8'h01, 1'b1, 1'b0};
    tbl[3] = '{48'h123456789ABC, 48'hDEF012345678, 16'd1501, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[4] = '{48'h000000000001, 48'h000000000002, 16'd0,    1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{48'hA5A5A5A5A5A5, 48'h5A5A5A5A5A5A, 16'd46,   1'b0, 1'b0, 1'b0, 8'h10, 8'h03, 1'b1, 1'b0};
    tbl[6] = '{48'h0102030405D5, 48'h55D555D55555, 16'd0,    1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{48'hCAFEBABE0001, 48'hFEEDFACE0002, 16'd45,   1'b0, 1'b1, 1'b1, 8'h7F, 8'h05, 1'b0, 1'b0};
    tbl[8] = '{48'h665544332211, 48'h0F0E0D0C0B0A, 16'd1500, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0};

    i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_no_padding = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    i_rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Table frames back to back, including the oversize length that aborts early.
    for (int t = 0; t < 9; t++) run_frame(tbl[t]);
    idle_cycle();
    repeat (3) idle_cycle();

    // Short preamble then SFD must be dropped; the frame that follows decodes.
    for (int i = 0; i < 5; i++) send_byte(8'h55);
    send_byte(8'hD5);
    run_frame(tbl[0]);
    idle_cycle();
    repeat (3) idle_cycle();

    // Length error pulse lands exactly one cycle after header byte 13.
    i_no_padding = 1'b0;
    build(tbl[3]);
    expect_frame(tbl[3]);
    send_fb(1'b0);
    idle_cycle();
    check("len_err_timing", {127'd0, o_len_err}, 1);
    check("busy_after_len_err", {127'd0, o_busy}, 0);
    idle_cycle();
    check("len_err_one_cycle", {127'd0, o_len_err}, 0);
    run_frame(tbl[5]);
    idle_cycle();
    repeat (3) idle_cycle();

    // Reset asserted with payload byte 20 on the bus discards the frame.
    fr = '{48'h111111111111, 48'h222222222222, 16'd40, 1'b0, 1'b0, 1'b0, 8'h30, 8'h01, 1'b1, 1'b0};
    i_no_padding = 1'b0;
    build(fr);
    exp_hdr_q.push_back('{fr.dest, fr.src, fr.len});
    for (int i = 0; i < 20; i++) exp_data_q.push_back(pay_byte(fr, i));
    for (int i = 0; i < 42; i++) send_byte(fb[i]);
    check("busy_mid_payload", {127'd0, o_busy}, 1);
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_data  = fb[42];
    i_rst   = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset_mid_payload");
    i_rst   = 1'b0;
    i_valid = 1'b0;
    run_frame(tbl[2]);
    idle_cycle();
    run_frame(tbl[0]);
    idle_cycle();
    repeat (5) idle_cycle();

    check("hdr_left", 128'(exp_hdr_q.size()), 0);
    check("data_left", 128'(exp_data_q.size()), 0);
    check("done_left", 128'(exp_done_q.size()), 0);
    check("len_err_left", 128'(exp_lenerr_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
